// File: rtl/core_pkg.sv
// Shared constants, instruction field layout, FSM encoding and writeback payload for the core.
package core_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 2;
    localparam int unsigned NREGS   = 2 ** ADDR_W;
    localparam int unsigned INSTR_W = 8;
    localparam int unsigned OPC_W   = 4;

    localparam logic [OPC_W-1:0] OPC_NOP  = 4'hF;
    localparam logic [OPC_W-1:0] OPC_HALT = 4'hE;

    localparam int unsigned OPC_HI = 7;
    localparam int unsigned OPC_LO = 4;
    localparam int unsigned RD_HI  = 3;
    localparam int unsigned RD_LO  = 2;
    localparam int unsigned RS1_HI = 1;
    localparam int unsigned RS1_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_t;

    function automatic logic [OPC_W-1:0] opc_of(input logic [INSTR_W-1:0] instr);
        return instr[OPC_HI:OPC_LO];
    endfunction

    function automatic logic [ADDR_W-1:0] rd_of(input logic [INSTR_W-1:0] instr);
        return instr[RD_HI:RD_LO];
    endfunction

    function automatic logic [ADDR_W-1:0] rs1_of(input logic [INSTR_W-1:0] instr);
        return instr[RS1_HI:RS1_LO];
    endfunction

    // Only real ALU ops produce a result worth committing.
    function automatic logic writes_back(input logic [OPC_W-1:0] opc);
        return (opc != OPC_NOP) && (opc != OPC_HALT);
    endfunction

endpackage

// File: rtl/reg_file.sv
// Register array: one synchronous write port, three asynchronous read ports, sync reset to zero.
module reg_file
    import core_pkg::*;
#(
    parameter int unsigned DW = DATA_W,
    parameter int unsigned AW = ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rd_addr,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] rs1_data,
    output logic [DW-1:0] rd_data,
    output logic [DW-1:0] dbg_data
);

    localparam int unsigned N = 2 ** AW;

    logic [DW-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rs1_data = mem[rs1_addr];
    assign rd_data  = mem[rd_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/regfile_stage.sv
// Register-read / writeback stage with run control (pc_en, HALT) and RAW hazard handling.
// Build option: define REGFILE_BYPASS_EN to forward the pending writeback instead of stalling.
module regfile_stage
    import core_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [INSTR_W-1:0] instruction,
    input  logic [DATA_W-1:0]  alu_out,
    output logic [DATA_W-1:0]  rs1_data,
    output logic [DATA_W-1:0]  rd_data,
    output logic               pc_en,
    output logic               halted,
    input  logic [ADDR_W-1:0]  dbg_addr,
    output logic [DATA_W-1:0]  dbg_data
);

    state_e             state_q;
    state_e             state_d;
    wb_t                wb_q;
    wb_t                wb_d;
    logic               halted_q;
    logic               halt_issue;
    logic               issue;
    logic               stall;
    logic [OPC_W-1:0]   opc;
    logic [ADDR_W-1:0]  rd;
    logic [ADDR_W-1:0]  rs1;
    logic [DATA_W-1:0]  rf_rs1;
    logic [DATA_W-1:0]  rf_rd;

    assign opc = opc_of(instruction);
    assign rd  = rd_of(instruction);
    assign rs1 = rs1_of(instruction);

    reg_file #(
        .DW (DATA_W),
        .AW (ADDR_W)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .we       (wb_q.valid),
        .waddr    (wb_q.addr),
        .wdata    (wb_q.data),
        .rs1_addr (rs1),
        .rd_addr  (rd),
        .dbg_addr (dbg_addr),
        .rs1_data (rf_rs1),
        .rd_data  (rf_rd),
        .dbg_data (dbg_data)
    );

`ifdef REGFILE_BYPASS_EN
    // Forward the not-yet-committed result so dependent instructions never wait.
    assign stall    = 1'b0;
    assign rs1_data = (wb_q.valid && (rs1 == wb_q.addr)) ? wb_q.data : rf_rs1;
    assign rd_data  = (wb_q.valid && (rd  == wb_q.addr)) ? wb_q.data : rf_rd;
`else
    // Hold one cycle so the pending commit lands before the operands are used.
    assign stall    = (state_q == ST_RUN) && wb_q.valid &&
                      ((rs1 == wb_q.addr) || (rd == wb_q.addr));
    assign rs1_data = rf_rs1;
    assign rd_data  = rf_rd;
`endif

    // State register, writeback register and halted flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wb_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wb_q     <= wb_d;
            halted_q <= halted_q | halt_issue;
        end
    end

    // Next-state and run-control decode.
    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        pc_en      = 1'b0;
        halt_issue = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                issue = !stall;
                if (issue) begin
                    if (opc == OPC_HALT) begin
                        halt_issue = 1'b1;
                        state_d    = ST_HALT;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture the ALU result of an issuing instruction; otherwise the slot empties.
    always_comb begin
        wb_d = '0;
        if (issue && writes_back(opc)) begin
            wb_d.valid = 1'b1;
            wb_d.addr  = rd;
            wb_d.data  = alu_out;
        end
    end

    assign halted = halted_q;

endmodule

// File: tb/tb_regfile_stage.sv
// Self-checking bench for regfile_stage: directed scenarios plus random traffic vs a behavioural model.
module tb_regfile_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] instruction;
    logic [7:0] alu_out;
    logic [7:0] rs1_data;
    logic [7:0] rd_data;
    logic       pc_en;
    logic       halted;
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int err_cnt = 0;
    int chk_cnt = 0;

    // Behavioural model: committed registers, one pending result, run/halt flags.
    logic [7:0] m_regs [4];
    bit         m_pend;
    logic [1:0] m_pend_addr;
    logic [7:0] m_pend_data;
    bit         m_run;
    bit         m_halt;
    bit         m_known = 1'b0;

    regfile_stage dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .instruction (instruction),
        .alu_out     (alu_out),
        .rs1_data    (rs1_data),
        .rd_data     (rd_data),
        .pc_en       (pc_en),
        .halted      (halted),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle, compare outputs against the model before the edge, then advance the model.
    task automatic step(input bit r, input bit s, input logic [7:0] ins,
                        input logic [7:0] alu, input logic [1:0] da);
        logic [3:0] opc;
        logic [1:0] rdv;
        logic [1:0] rsv;
        bit         stall_m;
        bit         iss;
        logic [7:0] e_rs1;
        logic [7:0] e_rd;

        rst         = r;
        start       = s;
        instruction = ins;
        alu_out     = alu;
        dbg_addr    = da;
        opc = ins[7:4];
        rdv = ins[3:2];
        rsv = ins[1:0];
        #2;

`ifdef REGFILE_BYPASS_EN
        stall_m = 1'b0;
`else
        stall_m = m_run && m_pend && ((rsv == m_pend_addr) || (rdv == m_pend_addr));
`endif
        iss   = m_run && !stall_m;
        e_rs1 = m_regs[rsv];
        e_rd  = m_regs[rdv];
`ifdef REGFILE_BYPASS_EN
        if (m_pend && rsv == m_pend_addr) e_rs1 = m_pend_data;
        if (m_pend && rdv == m_pend_addr) e_rd  = m_pend_data;
`endif

        if (m_known) begin
            check("pc_en",    8'(pc_en),  8'(iss && opc != 4'hE));
            check("halted",   8'(halted), 8'(m_halt));
            check("rs1_data", rs1_data,   e_rs1);
            check("rd_data",  rd_data,    e_rd);
            check("dbg_data", dbg_data,   m_regs[da]);
        end

        @(posedge clk);
        #1;
        if (r) begin
            for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
            m_pend  = 1'b0;
            m_run   = 1'b0;
            m_halt  = 1'b0;
            m_known = 1'b1;
        end else begin
            if (m_pend) m_regs[m_pend_addr] = m_pend_data;
            m_pend      = iss && opc != 4'hF && opc != 4'hE;
            m_pend_addr = rdv;
            m_pend_data = alu;
            if (!m_run && !m_halt && s) begin
                m_run = 1'b1;
            end else if (iss && opc == 4'hE) begin
                m_run  = 1'b0;
                m_halt = 1'b1;
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; instruction = 8'hF0; alu_out = 8'h00; dbg_addr = 2'd0;
        @(posedge clk);
        #1;

        // Reset and idle: everything reads zero, nothing runs.
        step(1, 0, 8'hF0, 8'h00, 2'd0);
        step(1, 0, 8'hF0, 8'h00, 2'd0);
        for (int a = 0; a < 4; a++) begin
            step(0, 0, 8'hF0, 8'h00, 2'(a));
            check("idle_dbg", dbg_data, 8'h00);
        end
        check("idle_pc_en", 8'(pc_en), 8'h00);

        // Start, then first write to reg1.
        step(0, 1, 8'h04, 8'hA5, 2'd1);
        step(0, 0, 8'h04, 8'hA5, 2'd1);
        step(0, 0, 8'hF0, 8'h00, 2'd1);
        check("t2_reg1", dbg_data, 8'hA5);

        // Back-to-back dependency on reg1.
        step(0, 0, 8'h04, 8'h3C, 2'd1);
        step(0, 0, 8'h01, 8'h00, 2'd1);
        step(0, 0, 8'h01, 8'h00, 2'd1);
        check("t3_reg1", dbg_data, 8'h3C);

        // NOP must not write and must not cause a stall.
        step(0, 0, 8'hF6, 8'hFF, 2'd1);
        instruction = 8'h05;
        #1;
        check("t4_no_stall", 8'(pc_en), 8'h01);
        step(0, 0, 8'h05, 8'h3C, 2'd1);
        step(0, 0, 8'hF0, 8'h00, 2'd1);
        check("t4_reg1", dbg_data, 8'h3C);

        // HALT behind a pending write to reg2.
        step(0, 0, 8'h08, 8'h77, 2'd2);
        step(0, 0, 8'hE0, 8'h00, 2'd2);
        check("t5_halted", 8'(halted), 8'h01);
        check("t5_reg2", dbg_data, 8'h77);
        for (int k = 0; k < 3; k++) step(0, 1, 8'h04, 8'h11, 2'd2);
        check("t5_still_halted", 8'(halted), 8'h01);
        check("t5_no_pc", 8'(pc_en), 8'h00);

        // Reset right after a capture drops the pending write.
        step(1, 0, 8'hF0, 8'h00, 2'd3);
        step(0, 1, 8'hF0, 8'h00, 2'd3);
        step(0, 0, 8'h0C, 8'h55, 2'd3);
        step(1, 0, 8'hF0, 8'h00, 2'd3);
        check("t6_reg3", dbg_data, 8'h00);
        check("t6_halted", 8'(halted), 8'h00);
        step(0, 0, 8'hF0, 8'h00, 2'd3);
        check("t6_wb_dropped", dbg_data, 8'h00);
        check("t6_idle", 8'(pc_en), 8'h00);

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            bit         r;
            bit         s;
            logic [7:0] ins;
            r   = ($urandom_range(0, 39) == 0);
            s   = ($urandom_range(0, 3) == 0);
            ins = 8'($urandom);
            if (ins[7:4] == 4'hE && $urandom_range(0, 3) != 0) ins[7:4] = 4'h1;
            step(r, s, ins, 8'($urandom), 2'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
